// File: rtl/bf16_pkg.sv
// Shared types for the bfloat16 lane serializer: word width, word type and FSM states.
package bf16_pkg;

  localparam int BF16_W = 16;

  typedef logic [BF16_W-1:0] bf16_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage : bf16_pkg

// File: rtl/bf16_lane_serializer_lane_counter.sv
// Lane index counter for the serializer. It can be cleared back to lane 0 or
// advanced by one lane, and it flags when it sits on the final lane.
module lane_counter
  import bf16_pkg::*;
#(
  parameter int N = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [LW-1:0] lane,
  output logic          is_last
);

  // Lane register: clear takes priority so a fresh vector always starts at lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (advance) begin
      lane <= lane + LW'(1);
    end
  end

  assign is_last = (lane == LW'(N - 1));

endmodule : lane_counter

// File: rtl/bf16_lane_serializer.sv
// Streams an N-lane packed bfloat16 result vector out one lane per beat over
// valid/ready. The final beat of a vector can capture the next vector in the
// same cycle, so back-to-back vectors stream without a bubble.
module bf16_lane_serializer
  import bf16_pkg::*;
#(
  parameter int N = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk1,
  input  logic                rst1,
  input  logic [16*N-1:0]     in_vec,
  input  logic                in_valid,
  output logic                in_ready,
  output bf16_t               out_data,
  output logic [LW-1:0]       out_lane,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);

  localparam int HW = BF16_W * N;

  ser_state_t      state;
  ser_state_t      state_next;
  logic [HW-1:0]   hold;
  logic            load_hold;
  logic            shift_hold;
  logic            zero_hold;
  logic            lane_clear;
  logic            lane_advance;
  logic [LW-1:0]   lane;
  logic            is_last;

  lane_counter #(.N(N)) u_lane_counter (
    .clk     (clk1),
    .rst     (rst1),
    .clear   (lane_clear),
    .advance (lane_advance),
    .lane    (lane),
    .is_last (is_last)
  );

  // State register for the IDLE/SEND controller.
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; in_ready never looks at in_valid.
  always_comb begin
    state_next   = state;
    load_hold    = 1'b0;
    shift_hold   = 1'b0;
    zero_hold    = 1'b0;
    lane_clear   = 1'b0;
    lane_advance = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst1;
        if (in_valid && !rst1) begin
          load_hold  = 1'b1;
          lane_clear = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        in_ready  = out_ready && is_last;
        if (out_ready) begin
          if (!is_last) begin
            shift_hold   = 1'b1;
            lane_advance = 1'b1;
          end else if (in_valid) begin
            load_hold  = 1'b1;
            lane_clear = 1'b1;
          end else begin
            zero_hold  = 1'b1;
            lane_clear = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hold shift register: the low word is always the lane being presented.
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      hold <= '0;
    end else if (load_hold) begin
      hold <= in_vec;
    end else if (shift_hold) begin
      hold <= hold >> BF16_W;
    end else if (zero_hold) begin
      hold <= '0;
    end
  end

  assign out_data = hold[BF16_W-1:0];
  assign out_lane = lane;
  assign out_last = (state == SEND) && is_last;
  assign busy     = (state == SEND);

endmodule : bf16_lane_serializer

// File: tb/tb_bf16_lane_serializer.sv
// Scoreboard bench for bf16_lane_serializer: one N=4 instance and one N=1
// instance share the clock and reset. Stimulus pushes expected beats into a
// queue per instance; independent monitors pop and compare on every beat.
module tb_bf16_lane_serializer;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  logic        clk1;
  logic        rst1;

  logic [63:0] in_vec_a;
  logic        in_valid_a;
  logic        in_ready_a;
  logic [15:0] out_data_a;
  logic [1:0]  out_lane_a;
  logic        out_valid_a;
  logic        out_ready_a;
  logic        out_last_a;
  logic        busy_a;

  logic [15:0] in_vec_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [15:0] out_data_b;
  logic [0:0]  out_lane_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic        out_last_b;
  logic        busy_b;

  int          total;
  int          bad;
  int          beats_a;
  int          beats_b;
  int          cyc;
  int          gap_cnt;
  logic        watch_gap;
  beat_t       exp_a[$];
  beat_t       exp_b[$];
  int          beat_cyc_b[$];

  bf16_lane_serializer #(.N(4)) dut_a (
    .clk1      (clk1),
    .rst1      (rst1),
    .in_vec    (in_vec_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .out_data  (out_data_a),
    .out_lane  (out_lane_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_last  (out_last_a),
    .busy      (busy_a)
  );

  bf16_lane_serializer #(.N(1)) dut_b (
    .clk1      (clk1),
    .rst1      (rst1),
    .in_vec    (in_vec_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_lane  (out_lane_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_last  (out_last_b),
    .busy      (busy_b)
  );

  // Free-running clock.
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Cycle counter used to prove consecutive beats.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk1);
      cyc++;
    end
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue expected beats, present the vector and hold it until captured.
  task automatic applyStimulus(input int dut, input logic [63:0] vec);
    beat_t e;
    logic  rdy;
    int    n;
    if (dut == 0) begin
      for (int i = 0; i < 4; i++) begin
        e.data = vec[16*i +: 16];
        e.lane = 2'(i);
        e.last = (i == 3);
        exp_a.push_back(e);
      end
      in_vec_a   = vec;
      in_valid_a = 1'b1;
    end else begin
      e.data = vec[15:0];
      e.lane = 2'b00;
      e.last = 1'b1;
      exp_b.push_back(e);
      in_vec_b   = vec[15:0];
      in_valid_b = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk1);
      rdy = (dut == 0) ? in_ready_a : in_ready_b;
      @(posedge clk1);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) checkOutput("capture_timeout", 64'd0, 64'd1);
    if (dut == 0) in_valid_a = 1'b0;
    else          in_valid_b = 1'b0;
  endtask

  // Wait (bounded) for an instance to return to IDLE.
  task automatic waitDrain(input int dut);
    logic b;
    int   n;
    n = 0;
    do begin
      @(negedge clk1);
      b = (dut == 0) ? busy_a : busy_b;
      n++;
    end while (b && n < 200);
    if (b) checkOutput("drain_timeout", 64'd1, 64'd0);
    @(posedge clk1);
    #1;
  endtask

  // Monitor for the N=4 instance: scoreboard pops plus stall-stability checks.
  initial begin
    beat_t       e;
    logic        stall;
    logic [15:0] st_data;
    logic [1:0]  st_lane;
    logic        st_last;
    stall   = 1'b0;
    st_data = '0;
    st_lane = '0;
    st_last = 1'b0;
    beats_a = 0;
    forever begin
      @(negedge clk1);
      if (rst1) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checkOutput("stall_data_a", out_data_a, st_data);
          checkOutput("stall_lane_a", out_lane_a, st_lane);
          checkOutput("stall_last_a", out_last_a, st_last);
        end
        if (out_valid_a && out_ready_a) begin
          beats_a++;
          if (exp_a.size() == 0) begin
            checkOutput("unexpected_beat_a", 64'd1, 64'd0);
          end else begin
            e = exp_a.pop_front();
            checkOutput("beat_data_a", out_data_a, e.data);
            checkOutput("beat_lane_a", out_lane_a, e.lane);
            checkOutput("beat_last_a", out_last_a, e.last);
          end
        end
        if (watch_gap && !out_valid_a) gap_cnt++;
        stall   = out_valid_a && !out_ready_a;
        st_data = out_data_a;
        st_lane = out_lane_a;
        st_last = out_last_a;
      end
    end
  end

  // Monitor for the N=1 instance: scoreboard pops and beat timestamps.
  initial begin
    beat_t e;
    beats_b = 0;
    forever begin
      @(negedge clk1);
      if (!rst1 && out_valid_b && out_ready_b) begin
        beats_b++;
        beat_cyc_b.push_back(cyc);
        if (exp_b.size() == 0) begin
          checkOutput("unexpected_beat_b", 64'd1, 64'd0);
        end else begin
          e = exp_b.pop_front();
          checkOutput("beat_data_b", out_data_b, e.data);
          checkOutput("beat_lane_b", {1'b0, out_lane_b}, e.lane);
          checkOutput("beat_last_b", out_last_b, e.last);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int   base;
    int   n;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    total       = 0;
    bad         = 0;
    gap_cnt     = 0;
    watch_gap   = 1'b0;
    in_vec_a    = '0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    in_vec_b    = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    rst1        = 1'b0;
    #1 rst1 = 1'b1;
    #1;
    checkOutput("rst_out_valid_a", out_valid_a, 64'd0);
    checkOutput("rst_out_data_a",  out_data_a,  64'd0);
    checkOutput("rst_out_lane_a",  out_lane_a,  64'd0);
    checkOutput("rst_out_last_a",  out_last_a,  64'd0);
    checkOutput("rst_busy_a",      busy_a,      64'd0);
    checkOutput("rst_in_ready_a",  in_ready_a,  64'd0);
    checkOutput("rst_out_last_b",  out_last_b,  64'd0);
    checkOutput("rst_in_ready_b",  in_ready_b,  64'd0);
    @(posedge clk1);
    @(posedge clk1);
    #2 rst1 = 1'b0;
    @(negedge clk1);
    checkOutput("post_rst_in_ready_a", in_ready_a, 64'd1);
    @(posedge clk1);
    #1;

    $display("[TB] test 1: basic stream");
    out_ready_a = 1'b1;
    base = beats_a;
    applyStimulus(0, 64'h4000_3F80_BF80_0000);
    waitDrain(0);
    checkOutput("t1_beats", beats_a - base, 64'd4);
    checkOutput("t1_in_ready_idle", in_ready_a, 64'd1);
    checkOutput("t1_out_valid_idle", out_valid_a, 64'd0);

    $display("[TB] test 2: backpressure");
    base = beats_a;
    applyStimulus(0, 64'h4000_3F80_BF80_0000);
    for (int k = 0; k < 7; k++) begin
      out_ready_a = pat[k];
      @(posedge clk1);
      #1;
    end
    checkOutput("t2_beats", beats_a - base, 64'd4);
    checkOutput("t2_busy_after", busy_a, 64'd0);
    out_ready_a = 1'b1;

    $display("[TB] test 3: back-to-back vectors");
    base = beats_a;
    applyStimulus(0, 64'h4000_3F80_BF80_0000);
    gap_cnt   = 0;
    watch_gap = 1'b1;
    applyStimulus(0, 64'h0001_0002_0003_0004);
    n = 0;
    while (beats_a < base + 8 && n < 100) begin
      @(posedge clk1);
      n++;
    end
    watch_gap = 1'b0;
    checkOutput("t3_beats", beats_a - base, 64'd8);
    checkOutput("t3_valid_gaps", gap_cnt, 64'd0);
    #1;
    waitDrain(0);

    $display("[TB] test 5: in_vec changes while streaming");
    applyStimulus(0, 64'hC0A0_4120_3E80_7F7F);
    for (int k = 0; k < 3; k++) begin
      in_vec_a = {$urandom, $urandom};
      @(posedge clk1);
      #1;
    end
    waitDrain(0);

    $display("[TB] test 4: reset mid-stream");
    applyStimulus(0, 64'hAAAA_BBBB_CCCC_DDDD);
    @(posedge clk1);
    #1;
    @(posedge clk1);
    #3 rst1 = 1'b1;
    #1;
    checkOutput("t4_out_valid", out_valid_a, 64'd0);
    checkOutput("t4_out_data",  out_data_a,  64'd0);
    checkOutput("t4_out_lane",  out_lane_a,  64'd0);
    checkOutput("t4_out_last",  out_last_a,  64'd0);
    checkOutput("t4_busy",      busy_a,      64'd0);
    checkOutput("t4_in_ready",  in_ready_a,  64'd0);
    exp_a.delete();
    @(posedge clk1);
    #2 rst1 = 1'b0;
    @(negedge clk1);
    checkOutput("t4_ready_after", in_ready_a, 64'd1);
    @(posedge clk1);
    #1;
    applyStimulus(0, 64'h1111_2222_3333_4444);
    waitDrain(0);

    $display("[TB] test 6: N=1 back-to-back");
    out_ready_b = 1'b1;
    beat_cyc_b.delete();
    applyStimulus(1, 64'h7FC0);
    applyStimulus(1, 64'hFF80);
    waitDrain(1);
    checkOutput("t6_beat_count", beat_cyc_b.size(), 64'd2);
    if (beat_cyc_b.size() == 2) begin
      checkOutput("t6_consecutive", beat_cyc_b[1] - beat_cyc_b[0], 64'd1);
    end

    checkOutput("leftover_a", exp_a.size(), 64'd0);
    checkOutput("leftover_b", exp_b.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bf16_lane_serializer
